// File: rtl/cc1200spi_apb_regs_v2.sv
// APB register front-end for the CC1200 SPI engine: control/status, data, GPIO and interrupt registers.
// The APB handshake is a small FSM; writes commit only in the single pready cycle.
module cc1200spi_apb_regs_v2 #(
    parameter int          GPIO_W      = 4,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] CLKDIV_RST  = 16'h0004
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       APB_S_0_paddr,
    input  logic              APB_S_0_psel,
    input  logic              APB_S_0_penable,
    input  logic              APB_S_0_pwrite,
    input  logic [31:0]       APB_S_0_pwdata,
    output logic [31:0]       APB_S_0_prdata,
    output logic              APB_S_0_pready,
    output logic              APB_S_0_pslverr,
    output logic              Start,
    input  logic              Busy,
    output logic [31:0]       DataOut,
    input  logic [31:0]       DataIn,
    output logic [3:0]        WR,
    output logic [15:0]       ClockDiv,
    output logic              Trans,
    output logic              Receive,
    output logic [GPIO_W-1:0] GPIO_OutEn,
    output logic [GPIO_W-1:0] GPIO_Out,
    input  logic [GPIO_W-1:0] GPIO_In,
    output logic [7:0]        Tx_Pkt_size,
    output logic [7:0]        Rx_Pkt_size,
    output logic [15:0]       Tx_wait,
    output logic [7:0]        CorThre,
    output logic              irq
);

    localparam int IRQ_W = 2 + GPIO_W;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

    apb_state_t        state;
    logic [3:0]        wait_cnt;
    logic              pready_q;
    logic              start_q;
    logic              busy_q;
    logic [31:0]       data_in_q;
    logic [GPIO_W-1:0] gpio_s1, gpio_s2, gpio_d;
    logic [IRQ_W-1:0]  irq_stat, irq_en, irq_set, irq_w1c;
    logic [7:0]        addr;
    logic [31:0]       rdata;
    logic              mapped, read_only, err, wr_en, start_rej, done;
    logic              unused_paddr;

    assign addr         = APB_S_0_paddr[7:0];
    assign unused_paddr = ^APB_S_0_paddr[31:8];

    // wait_cnt is a down-counter; pready is raised when it reaches its terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            pready_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (APB_S_0_psel && !APB_S_0_penable) state <= SETUP;
                end
                SETUP: begin
                    if (!APB_S_0_psel) begin
                        state <= IDLE;
                    end else begin
                        state    <= ACCESS;
                        wait_cnt <= 4'(WAIT_STATES);
                        pready_q <= (WAIT_STATES == 0);
                    end
                end
                ACCESS: begin
                    if (!APB_S_0_psel || pready_q) begin
                        state    <= IDLE;
                        pready_q <= 1'b0;
                    end else begin
                        if (wait_cnt == 4'd1) pready_q <= 1'b1;
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdata     = '0;
        mapped    = 1'b1;
        read_only = 1'b0;
        case (addr)
            8'h00: rdata[2:0] = {Receive, Trans, 1'b0};
            8'h04: begin rdata[1:0] = {start_q, busy_q}; read_only = 1'b1; end
            8'h08: rdata = DataOut;
            8'h0C: begin rdata = data_in_q; read_only = 1'b1; end
            8'h10: rdata[3:0] = WR;
            8'h14: rdata[15:0] = ClockDiv;
            8'h18: rdata[GPIO_W-1:0] = GPIO_OutEn;
            8'h1C: rdata[GPIO_W-1:0] = GPIO_Out;
            8'h20: begin rdata[GPIO_W-1:0] = gpio_s2; read_only = 1'b1; end
            8'h24: rdata[7:0] = Tx_Pkt_size;
            8'h28: rdata[7:0] = Rx_Pkt_size;
            8'h2C: rdata[15:0] = Tx_wait;
            8'h30: rdata[7:0] = CorThre;
            8'h34: rdata[IRQ_W-1:0] = irq_stat;
            8'h38: rdata[IRQ_W-1:0] = irq_en;
            default: mapped = 1'b0;
        endcase
    end

    assign err             = !mapped || (read_only && APB_S_0_pwrite);
    assign wr_en           = pready_q && APB_S_0_psel && APB_S_0_penable && APB_S_0_pwrite && !err;
    assign APB_S_0_pready  = pready_q;
    assign APB_S_0_prdata  = pready_q ? rdata : '0;
    assign APB_S_0_pslverr = pready_q && err;
    assign Start           = start_q;

    assign start_rej = wr_en && (addr == 8'h00) && APB_S_0_pwdata[0] && Busy;
    assign done      = busy_q && !Busy;
    assign irq_set   = {gpio_s2 & ~gpio_d, start_rej, done};
    assign irq_w1c   = (wr_en && addr == 8'h34) ? APB_S_0_pwdata[IRQ_W-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q     <= 1'b0;
            Trans       <= 1'b0;
            Receive     <= 1'b0;
            DataOut     <= '0;
            WR          <= '0;
            ClockDiv    <= CLKDIV_RST;
            GPIO_OutEn  <= '0;
            GPIO_Out    <= '0;
            Tx_Pkt_size <= '0;
            Rx_Pkt_size <= '0;
            Tx_wait     <= '0;
            CorThre     <= '0;
            irq_en      <= '0;
            irq_stat    <= '0;
            irq         <= 1'b0;
            busy_q      <= 1'b0;
            data_in_q   <= '0;
            gpio_s1     <= '0;
            gpio_s2     <= '0;
            gpio_d      <= '0;
        end else begin
            start_q <= 1'b0;
            if (wr_en) begin
                case (addr)
                    8'h00: begin
                        Trans   <= APB_S_0_pwdata[1];
                        Receive <= APB_S_0_pwdata[2];
                        if (APB_S_0_pwdata[0] && !Busy) start_q <= 1'b1;
                    end
                    8'h08: DataOut     <= APB_S_0_pwdata;
                    8'h10: WR          <= APB_S_0_pwdata[3:0];
                    8'h14: ClockDiv    <= APB_S_0_pwdata[15:0];
                    8'h18: GPIO_OutEn  <= APB_S_0_pwdata[GPIO_W-1:0];
                    8'h1C: GPIO_Out    <= APB_S_0_pwdata[GPIO_W-1:0];
                    8'h24: Tx_Pkt_size <= APB_S_0_pwdata[7:0];
                    8'h28: Rx_Pkt_size <= APB_S_0_pwdata[7:0];
                    8'h2C: Tx_wait     <= APB_S_0_pwdata[15:0];
                    8'h30: CorThre     <= APB_S_0_pwdata[7:0];
                    8'h38: irq_en      <= APB_S_0_pwdata[IRQ_W-1:0];
                    default: ;
                endcase
            end
            busy_q <= Busy;
            if (done) data_in_q <= DataIn;
            gpio_s1  <= GPIO_In;
            gpio_s2  <= gpio_s1;
            gpio_d   <= gpio_s2;
            // a hardware event wins over a simultaneous W1C of the same bit
            irq_stat <= (irq_stat & ~irq_w1c) | irq_set;
            irq      <= |(irq_stat & irq_en);
        end
    end

endmodule

// File: tb/tb_cc1200spi_apb_regs_v2.sv
// Self-checking bench: one DUT with no wait states, one with three, sharing the APB bus lines.
module tb_cc1200spi_apb_regs_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] paddr, pwdata, data_in;
    logic        psel0, psel3, penable, pwrite, busy;
    logic [3:0]  gpio_in;

    logic [31:0] prdata0, prdata3, dout0, dout3;
    logic        pready0, pready3, pslverr0, pslverr3, start0, start3;
    logic [3:0]  wr0, wr3, oen0, oen3, gout0, gout3;
    logic [15:0] cdiv0, cdiv3, txw0, txw3;
    logic        trans0, trans3, recv0, recv3, irq0, irq3;
    logic [7:0]  txp0, txp3, rxp0, rxp3, cor0, cor3;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    always @(negedge clk) if (start0 === 1'b1) start_cnt++;

    cc1200spi_apb_regs_v2 #(.GPIO_W(4), .WAIT_STATES(0), .CLKDIV_RST(16'h0004)) dut0 (
        .clk(clk), .rst(rst),
        .APB_S_0_paddr(paddr), .APB_S_0_psel(psel0), .APB_S_0_penable(penable),
        .APB_S_0_pwrite(pwrite), .APB_S_0_pwdata(pwdata), .APB_S_0_prdata(prdata0),
        .APB_S_0_pready(pready0), .APB_S_0_pslverr(pslverr0),
        .Start(start0), .Busy(busy), .DataOut(dout0), .DataIn(data_in), .WR(wr0),
        .ClockDiv(cdiv0), .Trans(trans0), .Receive(recv0),
        .GPIO_OutEn(oen0), .GPIO_Out(gout0), .GPIO_In(gpio_in),
        .Tx_Pkt_size(txp0), .Rx_Pkt_size(rxp0), .Tx_wait(txw0), .CorThre(cor0), .irq(irq0)
    );

    cc1200spi_apb_regs_v2 #(.GPIO_W(4), .WAIT_STATES(3), .CLKDIV_RST(16'h0004)) dut3 (
        .clk(clk), .rst(rst),
        .APB_S_0_paddr(paddr), .APB_S_0_psel(psel3), .APB_S_0_penable(penable),
        .APB_S_0_pwrite(pwrite), .APB_S_0_pwdata(pwdata), .APB_S_0_prdata(prdata3),
        .APB_S_0_pready(pready3), .APB_S_0_pslverr(pslverr3),
        .Start(start3), .Busy(busy), .DataOut(dout3), .DataIn(data_in), .WR(wr3),
        .ClockDiv(cdiv3), .Trans(trans3), .Receive(recv3),
        .GPIO_OutEn(oen3), .GPIO_Out(gout3), .GPIO_In(gpio_in),
        .Tx_Pkt_size(txp3), .Rx_Pkt_size(rxp3), .Tx_wait(txw3), .CorThre(cor3), .irq(irq3)
    );

    // lat = cycles from penable rising to pready; -1 when pready never came
    task automatic xfer(input bit use3, input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic err, output int lat);
        @(posedge clk); #1;
        paddr = addr; pwrite = wr; pwdata = wdata; penable = 1'b0;
        if (use3) psel3 = 1'b1; else psel0 = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = -1; rd = '0; err = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if ((use3 ? pready3 : pready0) === 1'b1) begin
                lat = n - 1;
                rd  = use3 ? prdata3 : prdata0;
                err = use3 ? pslverr3 : pslverr0;
                break;
            end
        end
        @(posedge clk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd, exp;
        logic err;
        int lat;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cdiv0 !== 16'h0004) begin errors++; $display("FAIL reset_clockdiv got %h want 0004", cdiv0); end
        checks++;
        if ({start0, irq0, pready0, pslverr0} !== 4'b0) begin
            errors++; $display("FAIL reset_ctl got %b want 0000", {start0, irq0, pready0, pslverr0});
        end
        checks++;
        if ({dout0, wr0, trans0, recv0, oen0, gout0, txp0, rxp0, txw0, cor0, prdata0} !== '0) begin
            errors++; $display("FAIL reset_outputs got nonzero dout=%h wr=%h txw=%h", dout0, wr0, txw0);
        end
        rst = 1'b0;
        exp_q.push_back(32'h0000_0004);
        xfer(0, 32'h14, 0, 0, rd, err, lat);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp || lat != 1) begin errors++; $display("FAIL reset_read_clkdiv got %h lat %0d want %h lat 1", rd, lat, exp); end
    endtask

    task automatic test_basic();
        logic [31:0] rd, exp;
        logic err;
        int lat;
        xfer(0, 32'h14, 1, 32'h1234, rd, err, lat);
        checks++;
        if (lat != 1 || err !== 1'b0) begin errors++; $display("FAIL basic_write lat %0d err %b want lat 1 err 0", lat, err); end
        checks++;
        if (cdiv0 !== 16'h1234) begin errors++; $display("FAIL basic_clockdiv got %h want 1234", cdiv0); end
        exp_q.push_back(32'h0000_1234);
        xfer(0, 32'h14, 0, 0, rd, err, lat);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp || lat != 1 || err !== 1'b0) begin
            errors++; $display("FAIL basic_read got %h lat %0d err %b want %h lat 1 err 0", rd, lat, err, exp);
        end
    endtask

    task automatic test_rw_walk();
        logic [31:0] addrs[9] = '{32'h08, 32'h10, 32'h18, 32'h1C, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h38};
        logic [31:0] masks[9] = '{32'hFFFF_FFFF, 32'hF, 32'hF, 32'hF, 32'hFF, 32'hFF, 32'hFFFF, 32'hFF, 32'h3F};
        logic [31:0] rd, exp, d;
        logic err;
        int lat;
        for (int i = 0; i < 9; i++) begin
            d = $urandom;
            xfer(0, addrs[i], 1, d, rd, err, lat);
            checks++;
            if (lat != 1 || err !== 1'b0) begin errors++; $display("FAIL walk_write addr %h lat %0d err %b", addrs[i], lat, err); end
            exp_q.push_back(d & masks[i]);
            xfer(0, addrs[i], 0, 0, rd, err, lat);
            exp = exp_q.pop_front();
            checks++;
            if (rd !== exp) begin errors++; $display("FAIL walk_read addr %h got %h want %h", addrs[i], rd, exp); end
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd, exp;
        logic err, seen;
        int lat;
        exp_q.push_back(32'h0);
        xfer(1, 32'h08, 0, 0, rd, err, lat);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp || lat != 4) begin errors++; $display("FAIL ws_read got %h lat %0d want %h lat 4", rd, lat, exp); end
        xfer(1, 32'h08, 1, 32'hCAFE_F00D, rd, err, lat);
        checks++;
        if (lat != 4 || err !== 1'b0) begin errors++; $display("FAIL ws_write lat %0d err %b want lat 4 err 0", lat, err); end
        @(posedge clk); #1;
        paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h1111_1111; psel3 = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        seen = 1'b0;
        repeat (8) begin @(negedge clk); seen |= pready3; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL ws_abort_pready got %b want 0", seen); end
        checks++;
        if (dout3 !== 32'hCAFE_F00D) begin errors++; $display("FAIL ws_abort_dataout got %h want cafef00d", dout3); end
        exp_q.push_back(32'hCAFE_F00D);
        xfer(1, 32'h08, 0, 0, rd, err, lat);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp || lat != 4) begin errors++; $display("FAIL ws_abort_read got %h lat %0d want %h lat 4", rd, lat, exp); end
    endtask

    task automatic test_start();
        logic [31:0] rd, exp;
        logic err;
        int lat, s0;
        busy = 1'b0;
        s0 = start_cnt;
        xfer(0, 32'h00, 1, 32'h7, rd, err, lat);
        repeat (4) @(negedge clk);
        checks++;
        if (start_cnt - s0 != 1 || lat != 1) begin errors++; $display("FAIL start_pulse cycles %0d want 1", start_cnt - s0); end
        checks++;
        if ({trans0, recv0} !== 2'b11) begin errors++; $display("FAIL start_trans_recv got %b want 11", {trans0, recv0}); end
        exp_q.push_back(32'h6);
        xfer(0, 32'h00, 0, 0, rd, err, lat);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL start_ctrl_read got %h want %h", rd, exp); end
        busy = 1'b1;
        repeat (2) @(negedge clk);
        s0 = start_cnt;
        xfer(0, 32'h00, 1, 32'h7, rd, err, lat);
        repeat (4) @(negedge clk);
        checks++;
        if (start_cnt != s0 || err !== 1'b0) begin errors++; $display("FAIL start_busy_pulse cycles %0d err %b want 0 0", start_cnt - s0, err); end
        exp_q.push_back(32'h2);
        exp_q.push_back(32'h1);
        xfer(0, 32'h34, 0, 0, rd, err, lat);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL start_rej_stat got %h want %h", rd, exp); end
        xfer(0, 32'h04, 0, 0, rd, err, lat);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL status_busy got %h want %h", rd, exp); end
    endtask

    task automatic test_done();
        logic [31:0] rd, exp;
        logic err;
        int lat;
        xfer(0, 32'h34, 1, 32'hFFFF_FFFF, rd, err, lat);
        xfer(0, 32'h38, 1, 32'h1, rd, err, lat);
        data_in = 32'hA5A5_0001;
        repeat (2) @(negedge clk);
        checks++;
        if (irq0 !== 1'b0) begin errors++; $display("FAIL done_irq_before got %b want 0", irq0); end
        @(posedge clk); #1;
        busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (irq0 !== 1'b0) begin errors++; $display("FAIL done_irq_lag got %b want 0", irq0); end
        @(negedge clk);
        checks++;
        if (irq0 !== 1'b1) begin errors++; $display("FAIL done_irq got %b want 1", irq0); end
        data_in = 32'h0;
        exp_q.push_back(32'hA5A5_0001);
        exp_q.push_back(32'h1);
        xfer(0, 32'h0C, 0, 0, rd, err, lat);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL done_data_in got %h want %h", rd, exp); end
        xfer(0, 32'h34, 0, 0, rd, err, lat);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL done_stat got %h want %h", rd, exp); end
        xfer(0, 32'h34, 1, 32'h1, rd, err, lat);
        repeat (2) @(negedge clk);
        checks++;
        if (irq0 !== 1'b0) begin errors++; $display("FAIL done_irq_clear got %b want 0", irq0); end
    endtask

    task automatic test_errors();
        logic [31:0] bad_a[4] = '{32'h0C, 32'h3C, 32'h04, 32'h20};
        logic [31:0] rd, exp;
        logic err;
        int lat;
        for (int i = 0; i < 4; i++) begin
            xfer(0, bad_a[i], 1, 32'hFFFF_FFFF, rd, err, lat);
            checks++;
            if (err !== 1'b1 || lat != 1) begin errors++; $display("FAIL err_write addr %h pslverr %b lat %0d want 1 1", bad_a[i], err, lat); end
        end
        exp_q.push_back(32'hA5A5_0001);
        xfer(0, 32'h0C, 0, 0, rd, err, lat);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp || err !== 1'b0) begin errors++; $display("FAIL err_data_in got %h err %b want %h 0", rd, err, exp); end
        exp_q.push_back(32'h0);
        xfer(0, 32'h3C, 0, 0, rd, err, lat);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp || err !== 1'b1) begin errors++; $display("FAIL err_unmapped_read got %h err %b want %h 1", rd, err, exp); end
        checks++;
        if (cdiv0 !== 16'h1234) begin errors++; $display("FAIL err_clockdiv got %h want 1234", cdiv0); end
    endtask

    task automatic test_gpio();
        logic [31:0] rd, exp;
        logic err;
        int lat;
        gpio_in = 4'b0001;
        repeat (4) @(negedge clk);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h4);
        xfer(0, 32'h20, 0, 0, rd, err, lat);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL gpio_in_read got %h want %h", rd, exp); end
        xfer(0, 32'h34, 0, 0, rd, err, lat);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL gpio_edge_stat got %h want %h", rd, exp); end
        xfer(0, 32'h34, 1, 32'h4, rd, err, lat);
        // GPIO_In[2] rises so that its synchronised edge lands on the W1C commit edge
        fork
            xfer(0, 32'h34, 1, 32'h10, rd, err, lat);
            begin @(posedge clk); #2; gpio_in[2] = 1'b1; end
        join
        exp_q.push_back(32'h10);
        xfer(0, 32'h34, 0, 0, rd, err, lat);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL gpio_set_wins got %h want %h", rd, exp); end
        xfer(0, 32'h34, 1, 32'h10, rd, err, lat);
        exp_q.push_back(32'h0);
        xfer(0, 32'h34, 0, 0, rd, err, lat);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL gpio_w1c got %h want %h", rd, exp); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, exp;
        logic err;
        int lat;
        @(posedge clk); #1;
        paddr = 32'h14; pwrite = 1'b1; pwdata = 32'hBEEF; psel0 = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (cdiv0 !== 16'h0004 || pready0 !== 1'b0) begin errors++; $display("FAIL midrst_clkdiv got %h pready %b want 0004 0", cdiv0, pready0); end
        checks++;
        if ({start0, irq0, pslverr0, dout0, wr0, trans0, recv0, oen0, gout0, txp0, rxp0, txw0, cor0} !== '0) begin
            errors++; $display("FAIL midrst_outputs got nonzero dout=%h oen=%h txp=%h", dout0, oen0, txp0);
        end
        psel0 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h14);
        xfer(0, 32'h14, 0, 0, rd, err, lat);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp || lat != 1) begin errors++; $display("FAIL midrst_resume got %h lat %0d want %h lat 1", rd, lat, exp); end
        xfer(0, 32'h34, 0, 0, rd, err, lat);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL midrst_sync_reedge got %h want %h", rd, exp); end
    endtask

    initial begin
        rst = 1'b1; paddr = '0; pwdata = '0; psel0 = 1'b0; psel3 = 1'b0;
        penable = 1'b0; pwrite = 1'b0; busy = 1'b0; data_in = '0; gpio_in = '0;
        test_reset();
        test_basic();
        test_rw_walk();
        test_wait_states();
        test_start();
        test_done();
        test_errors();
        test_gpio();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout reached before end of tests");
        $fatal(1);
    end

endmodule

// File: doc/cc1200spi_apb_regs_v2.md
CC1200SPI_APB_REGS_V2 -- requirements
Module: cc1200spi_apb_regs_v2

Interface
REQ-001 The block SHALL have parameter GPIO_W, default 4: GPIO width, 1..8.
REQ-002 The block SHALL have parameter WAIT_STATES, default 0: extra APB access cycles before pready, 0..15.
REQ-003 The block SHALL have parameter CLKDIV_RST, default 16'h0004: reset value of ClockDiv.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous assert, active-high.
REQ-006 The block SHALL have the APB slave ports paddr (in 32), psel (in 1), penable (in 1), pwrite (in 1), pwdata (in 32), prdata (out 32), pready (out 1) and pslverr (out 1), prefixed APB_S_0_.
REQ-007 The block SHALL have port Start, output, 1 bit: one-cycle transfer-start pulse.
REQ-008 The block SHALL have port Busy, input, 1 bit: SPI engine active.
REQ-009 The block SHALL have ports DataOut (out 32), DataIn (in 32), WR (out 4), ClockDiv (out 16), Trans (out 1) and Receive (out 1).
REQ-010 The block SHALL have ports GPIO_OutEn (out GPIO_W), GPIO_Out (out GPIO_W) and GPIO_In (in GPIO_W, asynchronous).
REQ-011 The block SHALL have ports Tx_Pkt_size (out 8), Rx_Pkt_size (out 8), Tx_wait (out 16) and CorThre (out 8).
REQ-012 The block SHALL have port irq, output, 1 bit: level interrupt, registered.

Function
REQ-013 The APB FSM SHALL use states IDLE, SETUP and ACCESS: IDLE goes to SETUP on psel & !penable, SETUP goes to ACCESS next cycle, ACCESS counts WAIT_STATES cycles, then asserts pready for exactly one cycle and returns to IDLE.
REQ-014 pready SHALL be asserted exactly 1+WAIT_STATES cycles after penable first rises; if psel drops mid-access, the FSM SHALL return to IDLE with no write committed.
REQ-015 Writes SHALL commit only in the pready cycle; prdata SHALL be valid and pslverr evaluated in that same cycle and be 0 otherwise.
REQ-016 The address decode SHALL use paddr[7:0]; pslverr SHALL be 1 for an unmapped address or a write to a read-only register, and such writes SHALL have no effect.
REQ-017 Address 0x00 CTRL SHALL be RW: [0] Start (write-1 requests a pulse, reads 0), [1] Trans, [2] Receive.
REQ-018 Address 0x04 STATUS SHALL be RO: [0] Busy, [1] Start pending/blocked.
REQ-019 Address 0x08 SHALL be DataOut RW, and 0x0C SHALL be DATA_IN RO holding the value captured from DataIn on the cycle Busy falls.
REQ-020 Addresses 0x10 WR[3:0], 0x14 ClockDiv[15:0], 0x18 GPIO_OutEn and 0x1C GPIO_Out SHALL be RW.
REQ-021 Address 0x20 GPIO_IN SHALL be RO, returning the 2-flop-synchronised GPIO_In.
REQ-022 Addresses 0x24 Tx_Pkt_size, 0x28 Rx_Pkt_size, 0x2C Tx_wait[15:0] and 0x30 CorThre SHALL be RW.
REQ-023 Address 0x34 IRQ_STAT SHALL be W1C: [0] DONE on Busy 1->0, [1] START_REJ, [2+:GPIO_W] rising edge of synced GPIO_In.
REQ-024 Address 0x38 IRQ_EN SHALL be RW with the same bit layout as IRQ_STAT.
REQ-025 Unused read bits SHALL read 0.
REQ-026 A Start write with Busy=0 SHALL produce a Start pulse the next cycle, high exactly one cycle.
REQ-027 A Start write with Busy=1 SHALL produce no pulse and SHALL set START_REJ.
REQ-028 Busy SHALL be sampled registered to detect its falling edge; DONE set and DATA_IN capture SHALL occur on the same cycle.
REQ-029 If hardware sets an IRQ_STAT bit in the same cycle that a W1C clears it, the bit SHALL end set.
REQ-030 irq SHALL equal the registered |(IRQ_STAT & IRQ_EN), one cycle after status or enable changes.

Reset
REQ-031 While rst=1, all registers SHALL be 0 except ClockDiv=CLKDIV_RST, and Start, irq, pready and pslverr SHALL be 0.
REQ-032 The GPIO synchroniser and Busy history SHALL reset to 0.
REQ-033 Reset asserted mid-access SHALL abort the access, and the FSM SHALL resume in IDLE.

Verification
REQ-034 With WAIT_STATES=0 and no reset activity, write 0x14=0x1234 then read 0x14 -> pready 1 cycle after penable, prdata=0x00001234, ClockDiv=0x1234, pslverr=0.
REQ-035 With WAIT_STATES=3, read 0x08 -> pready exactly 4 cycles after penable; psel dropped at cycle 2 -> no pready and no write.
REQ-036 Busy=0, write 0x00=0x7 -> single-cycle Start, Trans=1, Receive=1, 0x00 reads 0x6; repeat with Busy=1 -> no Start, IRQ_STAT[1]=1.
REQ-037 DataIn=0xA5A5_0001, Busy 1->0 with IRQ_EN=0x1 -> 0x0C reads 0xA5A50001, IRQ_STAT[0]=1, irq=1 next cycle; write 0x34=0x1 -> irq=0.
REQ-038 Write 0x0C or 0x3C -> pslverr=1 and the registers are unchanged.
REQ-039 GPIO_In[2] 0->1 coincident with a W1C of bit 4 -> bit 4 remains 1; rst pulse mid-access -> ClockDiv=0x0004 and all other outputs 0.
